// File: rtl/osd_mam_sram_target_if.sv
// MAM request / write / read channel bundle between the debug MAM initiator and
// the SRAM target.
interface osd_mam_sram_target_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_burst;
    logic [13:0]             req_beats;

    logic                    write_valid;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic                    write_ready;

    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
        output write_valid, write_data, write_strb,
        output read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
        input  write_valid, write_data, write_strb,
        input  read_ready,
        output req_ready, write_ready, read_valid, read_data
    );
endinterface

// File: rtl/osd_mam_sram_target.sv
// MAM memory-access responder: turns single/burst requests into word accesses on a
// 1-cycle-latency single-port SRAM, with a 2-entry read buffer for backpressure.
module osd_mam_sram_target #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    osd_mam_sram_target_if.slave         bus,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH/8-1:0]      sram_be,
    output logic [DATA_WIDTH-1:0]        sram_wdata,
    input  logic [DATA_WIDTH-1:0]        sram_rdata
);
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [13:0]        cnt_q, cnt_d;
    logic               burst_q, burst_d;
    logic               inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            fill_q;

    logic [ADDR_WIDTH-1:0] addr_off;
    logic [IDX_W-1:0]      req_idx;
    logic                  unused_addr_bits;
    logic                  push, pop, issue;
    logic [2:0]            occ;
    logic                  req_ready, write_ready;

    assign addr_off = bus.req_addr - BASE_ADDR;
    assign req_idx  = addr_off[BYTE_SHIFT +: IDX_W];
    // Sub-word and above-depth address bits never select a word.
    assign unused_addr_bits = ^addr_off;

    assign push = inflight_q;
    assign pop  = (fill_q != 2'd0) && bus.read_ready;
    // Words that will occupy the buffer after this edge, before any new issue.
    assign occ   = {1'b0, fill_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == StRead) && (cnt_q != '0) && (occ < 3'd2);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        inflight_d  = 1'b0;
        req_ready   = 1'b0;
        write_ready = 1'b0;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = idx_q;
        sram_be     = '0;
        sram_wdata  = bus.write_data;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    burst_d = bus.req_burst;
                    idx_d   = req_idx;
                    cnt_d   = bus.req_burst ? bus.req_beats : 14'd1;
                    state_d = bus.req_rw ? StWrite : StRead;
                end
            end
            StWrite: begin
                write_ready = (cnt_q != '0);
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else if (bus.write_valid) begin
                    sram_ce = 1'b1;
                    sram_we = 1'b1;
                    sram_be = burst_q ? {STRB_W{1'b1}} : bus.write_strb;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = cnt_q - 14'd1;
                    if (cnt_q == 14'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    sram_ce    = 1'b1;
                    idx_d      = idx_q + IDX_W'(1);
                    cnt_d      = cnt_q - 14'd1;
                    inflight_d = 1'b1;
                end else if ((cnt_q == '0) && !inflight_q) begin
                    state_d = (fill_q == 2'd0) ? StIdle : StDrain;
                end
            end
            StDrain: begin
                if (fill_q == 2'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= 1'b0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fill_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            inflight_q <= inflight_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.write_ready = write_ready;
    assign bus.read_valid  = (fill_q != 2'd0);
    assign bus.read_data   = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_osd_mam_sram_target.sv
// Directed bench for osd_mam_sram_target: 32-bit words, 16-word SRAM model with
// 1-cycle read latency.
module tb_osd_mam_sram_target;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 16;
    localparam int IW = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osd_mam_sram_target_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          sram_ce, sram_we;
    logic [IW-1:0] sram_addr;
    logic [SW-1:0] sram_be;
    logic [DW-1:0] sram_wdata, sram_rdata;

    osd_mam_sram_target #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_WORDS (MW),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_be   (sram_be),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    logic [DW-1:0] mem [MW];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.req_ready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_idle: req_ready got 0 want 1 within 40 cycles", name);
        end
    endtask

    task automatic issue_req(input bit rw, input logic [31:0] addr, input bit burst,
                             input logic [13:0] beats);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_burst = burst;
        bus.req_beats = beats;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: req_ready got %b want 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0;
        bus.req_burst = 1'b0; bus.req_beats = '0;
        bus.write_valid = 1'b0; bus.write_data = '0; bus.write_strb = '0;
        bus.read_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready);
        end
        n_cmp++;
        if (bus.read_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_read_valid: got %b want 0", bus.read_valid);
        end
        n_cmp++;
        if (bus.write_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_write_ready: got %b want 0", bus.write_ready);
        end
        n_cmp++;
        if ({sram_ce, sram_we} !== 2'b00) begin
            n_fail++; $display("FAIL rst_sram: ce/we got %b%b want 00", sram_ce, sram_we);
        end
    endtask

    task automatic test_burst_write_read();
        logic [42:0] got, exp;
        issue_req(1'b1, 32'h0, 1'b1, 14'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.write_valid = 1'b1;
            bus.write_data  = DW'(k + 1);
            #1;
            got = {bus.write_ready, sram_ce, sram_we, sram_addr, sram_be, sram_wdata};
            exp = {1'b1, 1'b1, 1'b1, IW'(k), 4'hF, DW'(k + 1)};
            n_cmp++;
            if (got !== exp) begin
                n_fail++; $display("FAIL bw_beat%0d: got %h want %h", k, got, exp);
            end
        end
        @(negedge clk);
        bus.write_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bw_done: req_ready got %b want 1", bus.req_ready);
        end
        bus.read_ready = 1'b1;
        issue_req(1'b0, 32'h0, 1'b1, 14'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({sram_ce, sram_we} !== {(k <= 4), 1'b0}) begin
                n_fail++;
                $display("FAIL br_ce_T%0d: ce/we got %b%b want %b0", k, sram_ce, sram_we, k <= 4);
            end
            if (k <= 4) begin
                n_cmp++;
                if (sram_addr !== IW'(k - 1)) begin
                    n_fail++; $display("FAIL br_addr_T%0d: got %0d want %0d", k, sram_addr, k - 1);
                end
            end
            n_cmp++;
            if (bus.read_valid !== ((k >= 3) && (k <= 6))) begin
                n_fail++; $display("FAIL br_valid_T%0d: got %b", k, bus.read_valid);
            end
            if ((k >= 3) && (k <= 6)) begin
                n_cmp++;
                if (bus.read_data !== DW'(k - 2)) begin
                    n_fail++; $display("FAIL br_data_T%0d: got %h want %h", k, bus.read_data, k - 2);
                end
            end
        end
        wait_idle("burst_rd");
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.write_valid = 1'b1;
        #1;
        n_cmp++;
        if ({bus.write_ready, sram_ce} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_wvalid: ready/ce got %b%b want 00", bus.write_ready, sram_ce);
        end
        bus.write_valid = 1'b0;
        issue_req(1'b1, 32'h8, 1'b0, 14'd5);
        @(negedge clk);
        bus.write_valid = 1'b1;
        bus.write_data  = 32'hAABBCCDD;
        bus.write_strb  = 4'b0011;
        #1;
        n_cmp++;
        if ({sram_ce, sram_we, sram_addr, sram_be, sram_wdata} !==
            {1'b1, 1'b1, 4'd2, 4'b0011, 32'hAABBCCDD}) begin
            n_fail++;
            $display("FAIL sw_sram: ce=%b we=%b addr=%0d be=%b wd=%h want 1 1 2 0011 aabbccdd",
                     sram_ce, sram_we, sram_addr, sram_be, sram_wdata);
        end
        @(negedge clk);
        bus.write_valid = 1'b0;
        #1;
        n_cmp++;
        if ({bus.req_ready, sram_ce} !== 2'b10) begin
            n_fail++;
            $display("FAIL sw_done: req_ready/ce got %b%b want 10", bus.req_ready, sram_ce);
        end
        bus.read_ready = 1'b1;
        issue_req(1'b0, 32'h8, 1'b0, 14'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.read_valid !== (k == 3)) begin
                n_fail++; $display("FAIL sr_valid_T%0d: got %b", k, bus.read_valid);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.read_data !== 32'h0000CCDD) begin
                    n_fail++; $display("FAIL sr_data: got %h want 0000ccdd", bus.read_data);
                end
            end
        end
        wait_idle("single");
    endtask

    task automatic test_backpressure();
        int wr_ok, issued, popped, max_occ;
        wr_ok = 0; issued = 0; popped = 0; max_occ = 0;
        issue_req(1'b1, 32'h10, 1'b1, 14'd8);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.write_valid = 1'b1;
            bus.write_data  = DW'(32'h10 + k);
            #1;
            if (bus.write_ready === 1'b1) wr_ok++;
        end
        @(negedge clk);
        bus.write_valid = 1'b0;
        n_cmp++;
        if (wr_ok != 8) begin
            n_fail++; $display("FAIL bp_writes: accepted %0d want 8", wr_ok);
        end
        bus.read_ready = 1'b0;
        issue_req(1'b0, 32'h10, 1'b1, 14'd8);
        for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
            @(negedge clk);
            bus.read_ready = ((cyc % 3) == 0);
            #1;
            if (sram_ce && !sram_we) issued++;
            if (bus.read_valid && bus.read_ready) begin
                n_cmp++;
                if (bus.read_data !== DW'(32'h10 + popped)) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h want %h", popped, bus.read_data, 32'h10 + popped);
                end
                popped++;
            end
            if (issued - popped > max_occ) max_occ = issued - popped;
        end
        n_cmp++;
        if (popped != 8 || issued != 8) begin
            n_fail++; $display("FAIL bp_count: popped %0d issued %0d want 8 8", popped, issued);
        end
        n_cmp++;
        if (max_occ > 2) begin
            n_fail++; $display("FAIL bp_occupancy: peak %0d want <=2", max_occ);
        end
        bus.read_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.read_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_extra: read_valid got %b want 0", bus.read_valid);
        end
        wait_idle("backpressure");
    endtask

    task automatic test_wrap();
        issue_req(1'b1, 32'h38, 1'b1, 14'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.write_valid = 1'b1;
            bus.write_data  = DW'(32'hA0 + k);
            #1;
            n_cmp++;
            if ({sram_ce, sram_addr} !== {1'b1, IW'((14 + k) % MW)}) begin
                n_fail++;
                $display("FAIL wrap_wr%0d: ce=%b addr=%0d want 1 %0d", k, sram_ce, sram_addr,
                         (14 + k) % MW);
            end
        end
        @(negedge clk);
        bus.write_valid = 1'b0;
        bus.read_ready  = 1'b1;
        issue_req(1'b0, 32'h38, 1'b1, 14'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            if (k <= 3) begin
                n_cmp++;
                if ({sram_ce, sram_addr} !== {1'b1, IW'((13 + k) % MW)}) begin
                    n_fail++;
                    $display("FAIL wrap_rd_T%0d: ce=%b addr=%0d want 1 %0d", k, sram_ce,
                             sram_addr, (13 + k) % MW);
                end
            end
            if (k >= 3) begin
                n_cmp++;
                if ({bus.read_valid, bus.read_data} !== {1'b1, DW'(32'hA0 + k - 3)}) begin
                    n_fail++;
                    $display("FAIL wrap_data_T%0d: valid=%b data=%h want 1 %h", k,
                             bus.read_valid, bus.read_data, 32'hA0 + k - 3);
                end
            end
        end
        wait_idle("wrap");
    endtask

    task automatic test_zero_beats();
        bus.read_ready = 1'b1;
        issue_req(1'b0, 32'h0, 1'b1, 14'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({bus.req_ready, sram_ce, bus.read_valid} !== {(k >= 2), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL zero_T%0d: req_ready=%b ce=%b rvalid=%b want %b 0 0", k,
                         bus.req_ready, sram_ce, bus.read_valid, k >= 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.read_ready = 1'b0;
        issue_req(1'b0, 32'h10, 1'b1, 14'd6);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (sram_ce !== 1'b1) begin
                n_fail++; $display("FAIL rm_issue_T%0d: ce got %b want 1", k, sram_ce);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({bus.read_valid, bus.req_ready, sram_ce} !== 3'b010) begin
            n_fail++;
            $display("FAIL rm_after: rvalid=%b req_ready=%b ce=%b want 0 1 0",
                     bus.read_valid, bus.req_ready, sram_ce);
        end
        bus.read_ready = 1'b1;
        issue_req(1'b0, 32'h8, 1'b0, 14'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.read_valid !== (k == 3)) begin
                n_fail++; $display("FAIL rm_valid_T%0d: got %b", k, bus.read_valid);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.read_data !== 32'h0000CCDD) begin
                    n_fail++; $display("FAIL rm_data: got %h want 0000ccdd", bus.read_data);
                end
            end
        end
        wait_idle("reset_mid");
    endtask

    initial begin
        test_reset();
        test_burst_write_read();
        test_single_write();
        test_backpressure();
        test_wrap();
        test_zero_beats();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/osd_mam_sram_target.md
Name: osd_mam_sram_target

Overview:
- Memory-side responder for the MAM memory-access interface. It accepts single and incremental-burst read/write requests from the MAM initiator.
- Translates each request into word accesses on a synchronous single-port SRAM with 1-cycle read latency.
- Sits between the debug MAM and a debug-accessible on-chip RAM. A 2-entry read buffer handles read backpressure.

Parameters:
- DATA_WIDTH, 16, word width in bits; multiple of 16.
- ADDR_WIDTH, 32, request byte-address width.
- MEM_WORDS, 1024, SRAM depth in words; power of 2, ≥2.
- BASE_ADDR, 0, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  new request
- req_ready  out  1  request accepted
- req_rw  in  1  0 read, 1 write
- req_addr  in  ADDR_WIDTH  byte base address
- req_burst  in  1  0 single beat, 1 incremental burst
- req_beats  in  14  burst length in words
- write_valid  in  1  write data valid
- write_data  in  DATA_WIDTH  write word
- write_strb  in  DATA_WIDTH/8  byte strobe (single beat only)
- write_ready  out  1  write word accepted
- read_valid  out  1  read word valid
- read_data  out  DATA_WIDTH  read word
- read_ready  in  1  read word consumed
- sram_ce  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  $clog2(MEM_WORDS)  SRAM word index
- sram_be  out  DATA_WIDTH/8  SRAM byte enables
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data; valid the cycle after a read-enable cycle

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE; beat counter, in-flight flag and buffer count clear.
  - read_valid=0, write_ready=0, sram_ce=0, sram_we=0.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-transaction abandons it; buffered read data is discarded.
- Index computation: word index = ((req_addr − BASE_ADDR) >> log2(DATA_WIDTH/8)), truncated to log2(MEM_WORDS) bits.
  - Burst index increments by 1 per beat and wraps MEM_WORDS−1 → 0.
  - Low address bits below word granularity are ignored.
- Beat count: burst=0 → 1 beat (req_beats ignored). burst=1 → req_beats beats. burst=1 with req_beats=0 → zero beats: accept, return to IDLE next cycle, no SRAM access.
- State IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch rw, burst, index and beat count.
  - Next state is WRITE (rw=1) or READ (rw=0).
- State WRITE:
  - write_ready=1.
  - On write_valid (handshake), in the same cycle: sram_ce=1, sram_we=1, sram_addr=index, sram_wdata=write_data.
  - sram_be = write_strb if burst=0, else all ones.
  - Index++ and count−−; count reaching 0 → IDLE.
  - No handshake → SRAM idle.
- State READ: issue a read (sram_ce=1, sram_we=0, sram_addr=index) when both hold:
  - beats remain;
  - buffered + in-flight − (read_valid&read_ready) < 2.
  - On issue: index++, count−−, in-flight set for the next cycle.
  - When in-flight, sram_rdata is written into the 2-entry FIFO at that clock edge.
  - When count reaches 0 and nothing is in flight → DRAIN.
- State DRAIN: req_ready=0 until the FIFO is empty, then → IDLE.
- Read port:
  - read_valid = FIFO non-empty; read_data = FIFO head.
  - read_data is held stable while read_valid&!read_ready.
  - Simultaneous push and pop is allowed.
  - The FIFO never overflows; the issue rule guarantees this.
- Latency (T = request handshake cycle):
  - First SRAM read is in T+1; first read_valid is in T+3.
  - With read_ready held high, one word per cycle thereafter.
  - Write: first write_ready is in T+1.
- Illegal or ignored inputs:
  - write_valid outside WRITE is ignored.
  - req_valid outside IDLE is not accepted.
  - read_ready with read_valid=0 has no effect.
- Outputs write_ready, req_ready and sram_* are combinational from registered state and inputs. read_* come from registers.

Test Plan:
- Single write, DATA_WIDTH=32, addr 0x8, strb 0011, data 0xAABBCCDD → one cycle with sram_ce=1, sram_we=1, sram_addr=2, sram_be=0011; state returns to IDLE.
- Burst write of 4 beats at 0x0 (data 1,2,3,4), then burst read of 4 beats with read_ready=1:
  - Write data appears on consecutive write handshakes.
  - Read returns 1,2,3,4 on read_valid cycles T+3..T+6.
- Burst read of 8 beats with read_ready toggling 1,0,0,1,… → all 8 words returned in order, none lost or duplicated; never more than 2 buffered-plus-in-flight words.
- Burst read of 3 beats starting at word MEM_WORDS−2 → sram_addr sequence MEM_WORDS−2, MEM_WORDS−1, 0.
- burst=1, req_beats=0 → req_ready=1 again at T+2; no sram_ce and no read_valid.
- Reset asserted after 2 of 6 beats of a read with read_ready=0 → next cycle read_valid=0, req_ready=1; a new single read then returns the correct word.
